dmem_write_buffer: RTL and testbench

DMEM_WRITE_BUFFER -- requirements
Module: dmem_write_buffer

---
 rtl/dmem_write_buffer.sv | 129 ++++++++++++
 tb/tb_dmem_write_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted-store write buffer between the CPU data port and
// backing memory. Stores are queued in a circular FIFO of {addr[31:2], data}
// and drained to the bus one per accepted handshake, always from a registered
// head entry.
//
// Build option: define DMEM_WBUF_FWD_EN to let loads forward data from the
// youngest matching queued store. Without it, a load stalls until the buffer
// has fully drained and then reads straight from backing memory.
module dmem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  input  logic [31:0]              Mem_WrAddr,
  input  logic [31:0]              Mem_WrData,
  output logic [31:0]              ReadData,
  output logic                     Stall,
  output logic                     bus_valid,
  input  logic                     bus_ready,
  output logic [31:0]              bus_addr,
  output logic [31:0]              bus_wdata,
  output logic [31:0]              bus_rd_addr,
  input  logic [31:0]              bus_rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  // Pointer and occupancy state
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  // Entry storage; not reset, validity comes from head/count alone
  logic [DEPTH-1:0][29:0] addr_mem_q, addr_mem_d;
  logic [DEPTH-1:0][31:0] data_mem_q, data_mem_d;

  logic full, empty;
  logic push, pop;
  logic [31:0] rd_data;

  // Byte-offset bits of the CPU address are deliberately ignored
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^Mem_WrAddr[1:0];

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Stall from registered occupancy only; bus_ready never feeds back into it
  always_comb begin
    Stall = MemWrite && full;
`ifndef DMEM_WBUF_FWD_EN
    // A load must wait for the buffer to drain so memory holds the latest data.
    // A cycle with both strobes is a store, so the load term is masked then.
    if (MemRead && !MemWrite && !empty)
      Stall = 1'b1;
`endif
  end

  assign push = MemWrite && !Stall;
  assign pop  = bus_valid && bus_ready;

  // Next-state for pointers, count and the entry written at the tail
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      addr_mem_d[tail_q] = Mem_WrAddr[31:2];
      data_mem_d[tail_q] = Mem_WrData;
      tail_d             = tail_q + 1'b1;
    end
    if (pop)
      head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset discards everything pending
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage registers
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

  // Load data path
  always_comb begin
    rd_data = bus_rd_data;
`ifdef DMEM_WBUF_FWD_EN
    // Walk oldest to youngest so the last match wins (youngest store)
    if (MemRead && !MemWrite) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [PW-1:0] idx;
        idx = head_q + PW'(i);
        if (((PW+1)'(i) < count_q) && (addr_mem_q[idx] == Mem_WrAddr[31:2]))
          rd_data = data_mem_q[idx];
      end
    end
`endif
  end

  assign ReadData    = rd_data;
  assign bus_valid   = !empty;
  assign bus_addr    = {addr_mem_q[head_q], 2'b00};
  assign bus_wdata   = data_mem_q[head_q];
  assign bus_rd_addr = {Mem_WrAddr[31:2], 2'b00};
  assign count       = count_q;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer (DEPTH=4). A bus monitor records every
// accepted write; store order is compared against the stores the bench issued.
module tb_dmem_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [31:0] Mem_WrAddr, Mem_WrData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        bus_valid, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rd_addr, bus_rd_data;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  dmem_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData), .ReadData(ReadData),
    .Stall(Stall), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rd_addr(bus_rd_addr),
    .bus_rd_data(bus_rd_data), .count(count)
  );

  always #5 clk = ~clk;

  // Backing-memory view: every handshake seen at a rising edge
  always @(posedge clk)
    if (bus_valid && bus_ready)
      got_q.push_back({bus_addr, bus_wdata});

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single accepted store (caller guarantees no stall)
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite   = 1'b1;
    Mem_WrAddr = a;
    Mem_WrData = d;
    step();
    MemWrite   = 1'b0;
    exp_q.push_back({a & 32'hFFFF_FFFC, d});
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (count == 3'd0) break;
      step();
    end
    chk(tag, 64'(count), 64'd0);
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_n"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
    Mem_WrAddr = '0; Mem_WrData = '0; bus_ready = 1'b0; bus_rd_data = '0;
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(bus_valid), 64'd0);
    MemWrite = 1'b1; #1;
    chk("rst_stall", 64'(Stall), 64'd0);
    MemWrite = 1'b0;

    // Single store, one-cycle latency to the bus, no fall-through
    bus_ready = 1'b1;
    MemWrite = 1'b1; Mem_WrAddr = 32'h100; Mem_WrData = 32'hA5A5_A5A5; #1;
    chk("s1_valid_pre", 64'(bus_valid), 64'd0);
    chk("s1_stall", 64'(Stall), 64'd0);
    step();
    MemWrite = 1'b0;
    exp_q.push_back({32'h100, 32'hA5A5_A5A5});
    chk("s1_valid", 64'(bus_valid), 64'd1);
    chk("s1_addr", 64'(bus_addr), 64'h100);
    chk("s1_wdata", 64'(bus_wdata), 64'hA5A5_A5A5);
    chk("s1_count", 64'(count), 64'd1);
    step();
    chk("s1_count0", 64'(count), 64'd0);
    chk("s1_valid0", 64'(bus_valid), 64'd0);
    check_order("s1_ord");

    // Byte offset ignored on the bus address
    store(32'h1F3, 32'h0000_0011);
    chk("lsb_addr", 64'(bus_addr), 64'h1F0);
    step();
    check_order("lsb_ord");

    // Fill to DEPTH with bus blocked, fifth store stalls
    bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h400 + 32'(4*i), 32'h10 + 32'(i));
    chk("full_count", 64'(count), 64'd4);
    chk("full_addr", 64'(bus_addr), 64'h400);
    MemWrite = 1'b1; Mem_WrAddr = 32'h410; Mem_WrData = 32'h14; #1;
    chk("full_stall", 64'(Stall), 64'd1);
    step();
    chk("full_count_hold", 64'(count), 64'd4);
    chk("full_stall_hold", 64'(Stall), 64'd1);
    chk("hold_addr", 64'(bus_addr), 64'h400);
    chk("hold_wdata", 64'(bus_wdata), 64'h10);
    chk("hold_valid", 64'(bus_valid), 64'd1);
    bus_ready = 1'b1; #1;
    chk("ready_no_stall_effect", 64'(Stall), 64'd1);
    step();
    chk("pop1_count", 64'(count), 64'd3);
    chk("pop1_stall", 64'(Stall), 64'd0);
    step();
    MemWrite = 1'b0;
    exp_q.push_back({32'h410, 32'h14});
    chk("retry_count", 64'(count), 64'd3);
    drain("full_drain");
    check_order("full_ord");

    // Simultaneous push/pop at count=2, streaming across pointer wrap
    bus_ready = 1'b0;
    store(32'h500, 32'h20);
    store(32'h504, 32'h21);
    chk("pp_count_init", 64'(count), 64'd2);
    bus_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      store(32'h508 + 32'(4*i), 32'h22 + 32'(i));
      chk($sformatf("pp_count_%0d", i), 64'(count), 64'd2);
    end
    drain("pp_drain");
    check_order("pp_ord");

    // Read address and plain read data path
    bus_rd_data = 32'hDEAD_BEEF;
    Mem_WrAddr  = 32'h302; #1;
    chk("rd_addr", 64'(bus_rd_addr), 64'h300);
    chk("rd_data_idle", 64'(ReadData), 64'hDEAD_BEEF);

`ifdef DMEM_WBUF_FWD_EN
    // Forward youngest matching store; non-matching reads from memory
    bus_ready = 1'b0;
    store(32'h200, 32'd1);
    store(32'h200, 32'd2);
    store(32'h204, 32'd3);
    MemRead = 1'b1; Mem_WrAddr = 32'h201; #1;
    chk("fwd_data", 64'(ReadData), 64'd2);
    chk("fwd_stall", 64'(Stall), 64'd0);
    Mem_WrAddr = 32'h208; #1;
    chk("fwd_miss", 64'(ReadData), 64'hDEAD_BEEF);
    MemRead = 1'b0;
    bus_ready = 1'b1;
    drain("fwd_drain");
    check_order("fwd_ord");
`else
    // Load waits for the buffer to drain
    bus_ready = 1'b0;
    store(32'h300, 32'h33);
    MemRead = 1'b1; Mem_WrAddr = 32'h300; #1;
    chk("ld_stall", 64'(Stall), 64'd1);
    step();
    chk("ld_stall_hold", 64'(Stall), 64'd1);
    chk("ld_count_hold", 64'(count), 64'd1);
    bus_ready = 1'b1;
    step();
    chk("ld_count0", 64'(count), 64'd0);
    chk("ld_stall0", 64'(Stall), 64'd0);
    chk("ld_data", 64'(ReadData), 64'hDEAD_BEEF);
    MemRead = 1'b0;
    check_order("ld_ord");
`endif

    // Reset discards pending entries
    bus_ready = 1'b0;
    store(32'h600, 32'h60);
    store(32'h604, 32'h61);
    store(32'h608, 32'h62);
    chk("rr_count3", 64'(count), 64'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_count", 64'(count), 64'd0);
    chk("rr_valid", 64'(bus_valid), 64'd0);
    bus_ready = 1'b1;
    repeat (5) step();
    chk("rr_no_writes", 64'(got_q.size()), 64'd0);
    chk("rr_count_after", 64'(count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
